// File: rtl/ps2_scancode_rx_pkg.sv
// ps2_scancode_rx_pkg
//   Shared definitions for the PS/2 scan-code receiver and the colour stage
//   that consumes its output: receiver FSM states, PS/2 prefix codes, the
//   colour key codes and a parity helper.
//   Configuration macro used by the receiver: PS2_BREAK_FILTER_EN.
package ps2_scancode_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2State_e;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  localparam logic [7:0] KEY_R = 8'h2d;
  localparam logic [7:0] KEY_G = 8'h34;
  localparam logic [7:0] KEY_B = 8'h32;
  localparam logic [7:0] KEY_W = 8'h1d;

  // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
  function automatic logic oddParityOk(input logic [7:0] dataBits, input logic parityBit);
    return ^{dataBits, parityBit};
  endfunction

endpackage

// File: rtl/ps2_scancode_rx_clk_filter.sv
// ps2_scancode_rx_clk_filter
//   Brings the raw PS/2 lines into the Pixelclock domain and removes glitches
//   from ps2 clock so that only clean 1->0 transitions reach the receiver FSM.
// Ports
//   Pixelclock   in   system clock, all logic on posedge
//   reset        in   asynchronous active-high reset
//   ps2Clk_i     in   raw PS/2 clock (asynchronous)
//   ps2Data_i    in   raw PS/2 data (asynchronous)
//   dataSync_o   out  synchronised PS/2 data
//   fallPulse_o  out  one-cycle pulse on each filtered ps2 clock falling edge
module ps2_scancode_rx_clk_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8
) (
  input  logic Pixelclock,
  input  logic reset,
  input  logic ps2Clk_i,
  input  logic ps2Data_i,
  output logic dataSync_o,
  output logic fallPulse_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] clkSync_q;
  logic [SYNC_STAGES-1:0] dataSync_q;
  logic [CW-1:0]          filtCnt_q;
  logic                   level_q;
  logic                   fall_q;

  // Synchronisers reset to the idle-high level of the bus so that leaving
  // reset never looks like a falling edge.
  always_ff @(posedge Pixelclock or posedge reset) begin
    if (reset) begin
      clkSync_q  <= '1;
      dataSync_q <= '1;
    end else begin
      clkSync_q  <= {clkSync_q[SYNC_STAGES-2:0], ps2Clk_i};
      dataSync_q <= {dataSync_q[SYNC_STAGES-2:0], ps2Data_i};
    end
  end

  // The filtered level only follows the synchronised clock after FILTER_LEN
  // consecutive samples disagree with it; any agreeing sample restarts the count.
  always_ff @(posedge Pixelclock or posedge reset) begin
    if (reset) begin
      filtCnt_q <= '0;
      level_q   <= 1'b1;
      fall_q    <= 1'b0;
    end else begin
      fall_q <= 1'b0;
      if (clkSync_q[SYNC_STAGES-1] == level_q) begin
        filtCnt_q <= '0;
      end else if (filtCnt_q == CW'(FILTER_LEN - 1)) begin
        filtCnt_q <= '0;
        level_q   <= clkSync_q[SYNC_STAGES-1];
        fall_q    <= level_q;
      end else begin
        filtCnt_q <= filtCnt_q + 1'b1;
      end
    end
  end

  assign dataSync_o  = dataSync_q[SYNC_STAGES-1];
  assign fallPulse_o = fall_q;

endmodule

// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx
//   PS/2 keyboard receiver. Collects device-to-host frames (start, 8 data bits
//   LSB first, odd parity, stop) and presents each accepted scan code on colour
//   with a one-cycle colour_check strobe. Malformed or stalled frames give a
//   one-cycle frame_error strobe.
//   Define PS2_BREAK_FILTER_EN to hide key-release sequences (F0 xx) and the
//   E0 prefix from the colour stage.
// Ports
//   Pixelclock    in   system clock, all logic on posedge
//   reset         in   asynchronous active-high reset
//   ps2_clk       in   raw PS/2 clock
//   ps2_data      in   raw PS/2 data
//   colour        out  last accepted scan code, held between strobes
//   colour_check  out  one-cycle strobe, colour has been updated
//   frame_error   out  one-cycle strobe, frame rejected
module ps2_scancode_rx
  import ps2_scancode_rx_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic       Pixelclock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] colour,
  output logic       colour_check,
  output logic       frame_error
);

  localparam int             TW      = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic dataSync;
  logic fallPulse;

  ps2State_e     state_q,       state_d;
  logic [2:0]    bitCnt_q,      bitCnt_d;
  logic [7:0]    shift_q,       shift_d;
  logic          parityOk_q,    parityOk_d;
  logic [TW-1:0] timeout_q,     timeout_d;
  logic [7:0]    colour_q,      colour_d;
  logic          colourCheck_q, colourCheck_d;
  logic          frameError_q,  frameError_d;
`ifdef PS2_BREAK_FILTER_EN
  logic          breakFlag_q,   breakFlag_d;
`endif

  ps2_scancode_rx_clk_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) uClkFilter (
    .Pixelclock  (Pixelclock),
    .reset       (reset),
    .ps2Clk_i    (ps2_clk),
    .ps2Data_i   (ps2_data),
    .dataSync_o  (dataSync),
    .fallPulse_o (fallPulse)
  );

  always_ff @(posedge Pixelclock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      bitCnt_q      <= '0;
      shift_q       <= '0;
      parityOk_q    <= 1'b0;
      timeout_q     <= '0;
      colour_q      <= '0;
      colourCheck_q <= 1'b0;
      frameError_q  <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
      breakFlag_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      bitCnt_q      <= bitCnt_d;
      shift_q       <= shift_d;
      parityOk_q    <= parityOk_d;
      timeout_q     <= timeout_d;
      colour_q      <= colour_d;
      colourCheck_q <= colourCheck_d;
      frameError_q  <= frameError_d;
`ifdef PS2_BREAK_FILTER_EN
      breakFlag_q   <= breakFlag_d;
`endif
    end
  end

  // One FSM step per filtered falling edge. The edge branch is checked before
  // the timeout so an edge landing on the threshold cycle keeps the frame alive.
  always_comb begin
    state_d       = state_q;
    bitCnt_d      = bitCnt_q;
    shift_d       = shift_q;
    parityOk_d    = parityOk_q;
    colour_d      = colour_q;
    colourCheck_d = 1'b0;
    frameError_d  = 1'b0;
`ifdef PS2_BREAK_FILTER_EN
    breakFlag_d   = breakFlag_q;
`endif

    // Saturating stall counter, held at zero while idle or on any edge.
    if (state_q == ST_IDLE || fallPulse) begin
      timeout_d = '0;
    end else if (timeout_q != TO_LAST) begin
      timeout_d = timeout_q + 1'b1;
    end else begin
      timeout_d = timeout_q;
    end

    if (fallPulse) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!dataSync) begin
            state_d  = ST_DATA;
            bitCnt_d = '0;
          end
        end
        ST_DATA: begin
          shift_d  = {dataSync, shift_q[7:1]};
          bitCnt_d = bitCnt_q + 1'b1;
          if (bitCnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
          parityOk_d = oddParityOk(shift_q, dataSync);
          state_d    = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (dataSync && parityOk_q) begin
`ifdef PS2_BREAK_FILTER_EN
            // F0 arms the release filter, E0 is transparent, and the byte
            // after F0 is the released key which is swallowed.
            if (shift_q == PS2_BREAK) begin
              breakFlag_d = 1'b1;
            end else if (shift_q == PS2_EXT) begin
              breakFlag_d = breakFlag_q;
            end else if (breakFlag_q) begin
              breakFlag_d = 1'b0;
            end else begin
              colour_d      = shift_q;
              colourCheck_d = 1'b1;
            end
`else
            colour_d      = shift_q;
            colourCheck_d = 1'b1;
`endif
          end else begin
            frameError_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE && timeout_q == TO_LAST) begin
      frameError_d = 1'b1;
      state_d      = ST_IDLE;
      bitCnt_d     = '0;
      shift_d      = '0;
    end
  end

  assign colour       = colour_q;
  assign colour_check = colourCheck_q;
  assign frame_error  = frameError_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb_ps2_scancode_rx
//   Self-checking bench for ps2_scancode_rx. A table of whole frames with
//   hand-computed strobe counts and colour values is replayed in a loop, then
//   hand-written sequences cover the clock glitch, the stall timeout and reset
//   arriving mid-frame. Expectations follow PS2_BREAK_FILTER_EN when defined.
module tb_ps2_scancode_rx;

  localparam int HALF = 40;

  logic       Pixelclock = 1'b0;
  logic       reset      = 1'b1;
  logic       ps2_clk    = 1'b1;
  logic       ps2_data   = 1'b1;
  logic [7:0] colour;
  logic       colour_check;
  logic       frame_error;

  int checks     = 0;
  int errors     = 0;
  int checkCount = 0;
  int errCount   = 0;
  int violations = 0;
  logic prevCheck = 1'b0;

  typedef struct {
    logic [7:0] code;
    logic       flipParity;
    int         expChecks;
    int         expErrs;
    logic [7:0] expColour;
  } vec_t;

  vec_t vecs[5];

  ps2_scancode_rx dut (
    .Pixelclock   (Pixelclock),
    .reset        (reset),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .colour       (colour),
    .colour_check (colour_check),
    .frame_error  (frame_error)
  );

  always #20 Pixelclock = ~Pixelclock;

  // Strobe counting away from the active edge, plus width and overlap rules.
  always @(negedge Pixelclock) begin
    if (colour_check) checkCount++;
    if (frame_error) errCount++;
    if (colour_check && prevCheck) violations++;
    if (colour_check && frame_error) violations++;
    prevCheck = colour_check;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drives the first nBits bits of a frame carrying code; flip inverts parity.
  task automatic applyStimulus(input logic [7:0] code, input logic flip, input int nBits);
    logic [10:0] frame;
    frame = {1'b1, (~^code) ^ flip, code, 1'b0};
    for (int i = 0; i < nBits; i++) begin
      ps2_data = frame[i];
      repeat (HALF) @(negedge Pixelclock);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge Pixelclock);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic frameAndCheck(input string name, input logic [7:0] code, input logic flip,
                               input int expC, input int expE, input logic [7:0] expColour);
    int c0;
    int e0;
    c0 = checkCount;
    e0 = errCount;
    applyStimulus(code, flip, 11);
    repeat (2 * HALF) @(negedge Pixelclock);
    checkOutput({name, " colour_check count"}, checkCount - c0, expC);
    checkOutput({name, " frame_error count"}, errCount - e0, expE);
    checkOutput({name, " colour"}, int'(colour), int'(expColour));
  endtask

  initial begin
    int c0;
    int e0;

    vecs[0] = '{8'h2d, 1'b0, 1, 0, 8'h2d};
    vecs[1] = '{8'h34, 1'b1, 0, 1, 8'h2d};
    vecs[2] = '{8'h32, 1'b0, 1, 0, 8'h32};
`ifdef PS2_BREAK_FILTER_EN
    vecs[3] = '{8'hF0, 1'b0, 0, 0, 8'h32};
    vecs[4] = '{8'h32, 1'b0, 0, 0, 8'h32};
`else
    vecs[3] = '{8'hF0, 1'b0, 1, 0, 8'hF0};
    vecs[4] = '{8'h32, 1'b0, 1, 0, 8'h32};
`endif

    repeat (5) @(negedge Pixelclock);
    checkOutput("reset colour", int'(colour), 0);
    checkOutput("reset colour_check", int'(colour_check), 0);
    checkOutput("reset frame_error", int'(frame_error), 0);
    reset = 1'b0;
    repeat (20) @(negedge Pixelclock);

    for (int i = 0; i < 5; i++) begin
      frameAndCheck($sformatf("vec%0d", i), vecs[i].code, vecs[i].flipParity,
                    vecs[i].expChecks, vecs[i].expErrs, vecs[i].expColour);
    end

    // Short low glitch with data low: a false edge would start a bogus frame.
    c0 = checkCount;
    e0 = errCount;
    ps2_data = 1'b0;
    repeat (HALF) @(negedge Pixelclock);
    ps2_clk = 1'b0;
    repeat (3) @(negedge Pixelclock);
    ps2_clk = 1'b1;
    repeat (HALF) @(negedge Pixelclock);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge Pixelclock);
    checkOutput("glitch colour_check count", checkCount - c0, 0);
    checkOutput("glitch frame_error count", errCount - e0, 0);
    frameAndCheck("after glitch", 8'h2d, 1'b0, 1, 0, 8'h2d);

    // Stalled frame: start plus five data bits, then the clock stays high.
    c0 = checkCount;
    e0 = errCount;
    applyStimulus(8'h32, 1'b0, 6);
    repeat (24800) @(negedge Pixelclock);
    checkOutput("timeout not early", errCount - e0, 0);
    repeat (400) @(negedge Pixelclock);
    checkOutput("timeout frame_error count", errCount - e0, 1);
    checkOutput("timeout colour_check count", checkCount - c0, 0);
    frameAndCheck("after timeout", 8'h1d, 1'b0, 1, 0, 8'h1d);

    // Reset during data bit 4 discards the partial frame silently.
    c0 = checkCount;
    e0 = errCount;
    applyStimulus(8'h2d, 1'b0, 5);
    reset = 1'b1;
    repeat (5) @(negedge Pixelclock);
    checkOutput("midreset colour", int'(colour), 0);
    checkOutput("midreset colour_check", int'(colour_check), 0);
    checkOutput("midreset frame_error", int'(frame_error), 0);
    reset = 1'b0;
    repeat (2 * HALF) @(negedge Pixelclock);
    checkOutput("midreset colour_check count", checkCount - c0, 0);
    checkOutput("midreset frame_error count", errCount - e0, 0);
    frameAndCheck("after midreset", 8'h2d, 1'b0, 1, 0, 8'h2d);

    checkOutput("strobe width/overlap violations", violations, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
